// File: rtl/router_switch_allocator.sv
// Wormhole switch allocator for a 5-port mesh router.
// Every output runs its own IDLE/LOCKED FSM with a round-robin pointer.
// A lock is held from the head flit to the tail flit. A per-output credit
// counter stops flits from reaching a full downstream buffer.
module router_switch_allocator #(
  parameter int NUM_PORTS   = 5,
  parameter int CREDIT_W    = 3,
  parameter int CREDIT_INIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   req_valid,
  input  logic [3*NUM_PORTS-1:0] req_outport,
  input  logic [NUM_PORTS-1:0]   req_tail,
  output logic [NUM_PORTS-1:0]   req_ready,
  output logic [NUM_PORTS-1:0]   out_valid,
  output logic [3*NUM_PORTS-1:0] out_sel,
  input  logic [NUM_PORTS-1:0]   credit_ret,
  output logic [NUM_PORTS-1:0]   out_lock,
  output logic                   err_bad_port,
  output logic                   err_credit
);

  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_PORTS - 1);
  localparam logic [CREDIT_W-1:0] CRED_MAX = CREDIT_W'(CREDIT_INIT);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

  // Per-output control state
  state_e              state_q  [NUM_PORTS];
  state_e              state_d  [NUM_PORTS];
  logic [IDX_W-1:0]    owner_q  [NUM_PORTS];
  logic [IDX_W-1:0]    owner_d  [NUM_PORTS];
  logic [IDX_W-1:0]    ptr_q    [NUM_PORTS];
  logic [IDX_W-1:0]    ptr_d    [NUM_PORTS];
  logic [CREDIT_W-1:0] credit_q [NUM_PORTS];
  logic [CREDIT_W-1:0] credit_d [NUM_PORTS];

  logic err_bad_q, err_bad_d;
  logic err_credit_q, err_credit_d;

  // Decoded per-input outport codes
  logic [IDX_W-1:0] port_code [NUM_PORTS];

  // Advance a port index by one, wrapping at the last port.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  // Round-robin pick: first set candidate after ptr, wrapping.
  // Returns {found, winner}.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_PORTS-1:0] cand,
                                             input logic [IDX_W-1:0]     ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win;
    logic             found;
    idx   = ptr;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = wrap_inc(idx);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  // Credit update. A transfer and a return in the same cycle cancel out.
  // A return at the maximum saturates instead of wrapping.
  function automatic logic [CREDIT_W-1:0] credit_next(input logic [CREDIT_W-1:0] cred,
                                                      input logic                xfer,
                                                      input logic                ret);
    logic [CREDIT_W-1:0] res;
    case ({xfer, ret})
      2'b10:   res = cred - CREDIT_W'(1);
      2'b01:   res = (cred == CRED_MAX) ? cred : cred + CREDIT_W'(1);
      default: res = cred;
    endcase
    return res;
  endfunction

  // Slice the flat outport bus into one code per input and flag illegal codes.
  always_comb begin
    err_bad_d = err_bad_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_code[i] = req_outport[3*i +: 3];
      if (req_valid[i] && (port_code[i] > LAST_IDX)) begin
        err_bad_d = 1'b1;
      end
    end
  end

  // Output FSMs: arbitration while idle, flit transfer and credit flow while locked.
  always_comb begin
    logic [NUM_PORTS-1:0] cand;
    logic [IDX_W:0]       pick;
    logic                 xfer;
    req_ready    = '0;
    out_valid    = '0;
    out_lock     = '0;
    out_sel      = '0;
    err_credit_d = err_credit_q;
    cand         = '0;
    pick         = '0;
    xfer         = 1'b0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      xfer       = 1'b0;
      cand       = '0;
      pick       = '0;

      out_lock[o]       = (state_q[o] == S_LOCKED);
      out_sel[3*o +: 3] = owner_q[o];

      if (state_q[o] == S_LOCKED) begin
        // Ready depends only on lock and credit, never on req_valid.
        // Nothing moves while reset is asserted.
        if ((credit_q[o] != '0) && !rst) begin
          req_ready[owner_q[o]] = 1'b1;
          if (req_valid[owner_q[o]]) begin
            xfer         = 1'b1;
            out_valid[o] = 1'b1;
            if (req_tail[owner_q[o]]) begin
              state_d[o] = S_IDLE;
              ptr_d[o]   = owner_q[o];
            end
          end
        end
      end else begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          cand[i] = req_valid[i] && (port_code[i] == IDX_W'(o));
        end
        pick = rr_pick(cand, ptr_q[o]);
        if (pick[IDX_W]) begin
          state_d[o] = S_LOCKED;
          owner_d[o] = pick[IDX_W-1:0];
        end
      end

      if (credit_ret[o] && (credit_q[o] == CRED_MAX)) begin
        err_credit_d = 1'b1;
      end
      credit_d[o] = credit_next(credit_q[o], xfer, credit_ret[o]);
    end
  end

  // State, pointer, credit and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o]  <= S_IDLE;
        owner_q[o]  <= '0;
        ptr_q[o]    <= LAST_IDX;
        credit_q[o] <= CRED_MAX;
      end
      err_bad_q    <= 1'b0;
      err_credit_q <= 1'b0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o]  <= state_d[o];
        owner_q[o]  <= owner_d[o];
        ptr_q[o]    <= ptr_d[o];
        credit_q[o] <= credit_d[o];
      end
      err_bad_q    <= err_bad_d;
      err_credit_q <= err_credit_d;
    end
  end

  assign err_bad_port = err_bad_q;
  assign err_credit   = err_credit_q;

endmodule

// File: tb/tb_router_switch_allocator.sv
// Bench for router_switch_allocator. Per-input flit queues act as the upstream
// side. A per-output scoreboard holds the expected owner of each transfer.
module tb_router_switch_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req_valid;
  logic [14:0] req_outport;
  logic [4:0]  req_tail;
  logic [4:0]  req_ready;
  logic [4:0]  out_valid;
  logic [14:0] out_sel;
  logic [4:0]  out_lock;
  logic        err_bad_port;
  logic        err_credit;
  logic [4:0]  credit_ret;
  logic [4:0]  ret_auto = '0;
  logic [4:0]  man_ret  = '0;
  logic [4:0]  auto_ret = '1;

  typedef struct packed {
    logic [2:0] port;
    logic       tail;
  } flit_t;

  flit_t      src_q [5][$];
  int         exp_q [5][$];
  logic [4:0] fire  = '0;
  logic [4:0] ofire = '0;

  int n_chk = 0;
  int n_err = 0;
  int cnt;

  assign credit_ret = ret_auto | man_ret;

  router_switch_allocator dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_outport  (req_outport),
    .req_tail     (req_tail),
    .req_ready    (req_ready),
    .out_valid    (out_valid),
    .out_sel      (out_sel),
    .credit_ret   (credit_ret),
    .out_lock     (out_lock),
    .err_bad_port (err_bad_port),
    .err_credit   (err_credit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int src, input int port, input int len);
    flit_t f;
    for (int k = 0; k < len; k++) begin
      f.port = 3'(port);
      f.tail = (k == len - 1);
      src_q[src].push_back(f);
    end
  endtask

  // Scoreboard: compare every transfer against the expected owner, and
  // record handshakes for the upstream model.
  always @(negedge clk) begin
    for (int o = 0; o < 5; o++) begin
      ofire[o] = (out_valid[o] === 1'b1);
      if (!rst && out_valid[o] === 1'b1) begin
        if (exp_q[o].size() == 0) begin
          chk($sformatf("sb_unexpected_out%0d", o), 32'(out_sel[3*o +: 3]), 32'hFF);
        end else begin
          chk($sformatf("sb_owner_out%0d", o), 32'(out_sel[3*o +: 3]), 32'(exp_q[o].pop_front()));
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      fire[i] = (req_valid[i] === 1'b1) && (req_ready[i] === 1'b1);
    end
  end

  // Upstream and downstream models: pop accepted flits, present the next
  // flit, and return one credit after each observed transfer.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 5; i++) begin
      if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_outport[3*i +: 3] = src_q[i][0].port;
        req_tail[i]          = src_q[i][0].tail;
      end else begin
        req_valid[i]         = 1'b0;
        req_outport[3*i +: 3] = 3'd0;
        req_tail[i]          = 1'b0;
      end
    end
    for (int o = 0; o < 5; o++) ret_auto[o] = auto_ret[o] & ofire[o];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v_pat [6];
    int s_pat [6];
    int r1_pat[6];
    int r3_pat[6];
    int seen;
    int last;
    int cyc;
    v_pat  = '{0, 1, 1, 1, 0, 1};
    s_pat  = '{0, 1, 1, 1, 1, 3};
    r1_pat = '{0, 1, 1, 1, 0, 0};
    r3_pat = '{0, 0, 0, 0, 0, 1};

    rst         = 1'b1;
    req_valid   = '0;
    req_outport = '0;
    req_tail    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_lock",   out_lock, 0);
    chk("rst_ready",  req_ready, 0);
    chk("rst_valid",  out_valid, 0);
    chk("rst_sel",    out_sel, 0);
    chk("rst_errbad", err_bad_port, 0);
    chk("rst_errcr",  err_credit, 0);

    // Single-flit packet from input 2 to south
    push_pkt(2, 3, 1);
    exp_q[3].push_back(2);
    @(negedge clk);
    chk("t1_alloc_lock",  out_lock, 0);
    chk("t1_alloc_ready", req_ready, 0);
    @(negedge clk);
    chk("t1_lock",  out_lock, 5'b01000);
    chk("t1_ready", req_ready, 5'b00100);
    chk("t1_valid", out_valid, 5'b01000);
    @(negedge clk);
    chk("t1_release", out_lock, 0);
    chk("t1_idle_valid", out_valid, 0);

    // Three inputs contend for output 0 with single-flit packets
    push_pkt(0, 0, 1); push_pkt(0, 0, 1);
    push_pkt(1, 0, 1); push_pkt(1, 0, 1);
    push_pkt(4, 0, 1); push_pkt(4, 0, 1);
    exp_q[0].push_back(0); exp_q[0].push_back(1); exp_q[0].push_back(4);
    exp_q[0].push_back(0); exp_q[0].push_back(1); exp_q[0].push_back(4);
    seen = 0; last = 0; cyc = 0;
    while (seen < 6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (out_valid[0]) begin
        seen++;
        last = cyc;
      end
    end
    chk("t2_count", seen, 6);
    chk("t2_cycles", last, 12);

    // Multi-flit packet holds output 2 against a competing input
    push_pkt(1, 2, 3);
    push_pkt(3, 2, 1);
    exp_q[2].push_back(1); exp_q[2].push_back(1);
    exp_q[2].push_back(1); exp_q[2].push_back(3);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("t3_valid_c%0d", k + 1), out_valid[2], v_pat[k]);
      chk($sformatf("t3_sel_c%0d", k + 1), out_sel[8:6], s_pat[k]);
      chk($sformatf("t3_rdy1_c%0d", k + 1), req_ready[1], r1_pat[k]);
      chk($sformatf("t3_rdy3_c%0d", k + 1), req_ready[3], r3_pat[k]);
    end
    @(negedge clk);

    // Credit exhaustion on output 1
    auto_ret[1] = 1'b0;
    push_pkt(0, 1, 6);
    repeat (6) exp_q[1].push_back(0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid[1]) cnt++;
    end
    chk("t4_burst", cnt, 4);
    chk("t4_stall_ready", req_ready[0], 0);
    chk("t4_lock_held", out_lock[1], 1);
    man_ret[1] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) man_ret[1] = 1'b0;
      if (out_valid[1]) cnt++;
    end
    chk("t4_one_more", cnt, 1);
    man_ret[1] = 1'b1;
    repeat (5) @(negedge clk);
    man_ret[1] = 1'b0;
    chk("t4_drained", exp_q[1].size(), 0);
    chk("t4_released", out_lock[1], 0);
    chk("t4_no_cred_err", err_credit, 0);
    auto_ret[1] = 1'b1;

    // Illegal outport code, then a credit return at full credit
    push_pkt(2, 6, 1);
    @(negedge clk);
    chk("t5_bad_before", err_bad_port, 0);
    @(negedge clk);
    chk("t5_bad_set", err_bad_port, 1);
    chk("t5_no_lock", out_lock, 0);
    chk("t5_no_ready", req_ready, 0);
    src_q[2].delete();
    man_ret[4] = 1'b1;
    @(negedge clk);
    man_ret[4] = 1'b0;
    chk("t5_err_credit", err_credit, 1);
    auto_ret[4] = 1'b0;
    push_pkt(3, 4, 5);
    repeat (4) exp_q[4].push_back(3);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid[4]) cnt++;
    end
    chk("t5_credit_cap", cnt, 4);
    chk("t5_stall_ready", req_ready[3], 0);
    chk("t5_bad_sticky", err_bad_port, 1);

    // Reset in the middle of a packet on output 2
    push_pkt(1, 2, 4);
    repeat (4) exp_q[2].push_back(1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_xfer1", out_valid[2], 1);
    @(negedge clk);
    chk("t6_xfer2", out_valid[2], 1);
    chk("t6_locked", out_lock[2], 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    man_ret = '0;
    for (int i = 0; i < 5; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    @(negedge clk);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("t6_post_lock",  out_lock, 0);
    chk("t6_post_ready", req_ready, 0);
    chk("t6_post_sel",   out_sel, 0);
    chk("t6_post_errb",  err_bad_port, 0);
    chk("t6_post_errc",  err_credit, 0);
    push_pkt(0, 2, 1);
    push_pkt(4, 2, 1);
    exp_q[2].push_back(0); exp_q[2].push_back(4);
    push_pkt(3, 4, 5);
    repeat (4) exp_q[4].push_back(3);
    cnt = 0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid[4]) cnt++;
      if (out_valid[2]) seen++;
    end
    chk("t6_credit_reinit", cnt, 4);
    chk("t6_out2_count", seen, 2);

    for (int o = 0; o < 5; o++) begin
      chk($sformatf("sb_drain_out%0d", o), exp_q[o].size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
